// File: rtl/mispred_recovery_ctrl.sv
// mispred_recovery_ctrl: sequences mispredict recovery, driving flush level, fetch redirect and rename stall.
// Handles older and full-flush overrides that arrive while a recovery is already in progress.
package mispred_pkg;
    localparam int SQN_W = 6;
    localparam int PC_W = 32;
    typedef struct packed {
        logic taken;
        logic flush;
        logic [SQN_W-1:0] sqN;
        logic [PC_W-1:0] dstPC;
    } BranchProv;
endpackage

module mispred_recovery_ctrl
    import mispred_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int PERFC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  BranchProv          IN_branch,
    input  logic               IN_redirReady,
    output logic               OUT_mispredFlush,
    output logic               OUT_redirValid,
    output logic [PC_W-1:0]    OUT_redirPC,
    output logic               OUT_redirFull,
    output logic               OUT_rnStall,
    output logic [SQN_W-1:0]   OUT_recSqN,
    output logic [PERFC_W-1:0] OUT_PERFC_recoveries,
    output logic [PERFC_W-1:0] OUT_PERFC_recoveryCycles
);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [SQN_W-1:0] sqn_q, sqn_d, sqn_diff;
    logic [PC_W-1:0] pc_q, pc_d;
    logic full_q, full_d, valid_q, valid_d;
    logic [PERFC_W-1:0] rec_q, rec_d, cyc_q, cyc_d;
    logic in_flush, start, ovr, load, xfer, exit_now;

    always_comb begin
        in_flush = state_q == FLUSH;
        sqn_diff = IN_branch.sqN - sqn_q;
        start = !in_flush && IN_branch.taken;
        // The sign bit of the wrapped difference marks the incoming branch as older.
        ovr = in_flush && IN_branch.taken && (IN_branch.flush || (!full_q && sqn_diff[SQN_W-1]));
        load = start || ovr;
        xfer = valid_q && IN_redirReady;
        exit_now = in_flush && cnt_q == 4'd0 && (!valid_q || xfer) && !ovr;
        state_d = load ? FLUSH : exit_now ? IDLE : state_q;
        cnt_d = load ? 4'(FLUSH_CYCLES - 1) : (in_flush && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        valid_d = load ? 1'b1 : xfer ? 1'b0 : valid_q;
        sqn_d = load ? IN_branch.sqN : sqn_q;
        pc_d = load ? IN_branch.dstPC : pc_q;
        full_d = load ? IN_branch.flush : full_q;
        rec_d = (start && !(&rec_q)) ? rec_q + PERFC_W'(1) : rec_q;
        cyc_d = (in_flush && !(&cyc_q)) ? cyc_q + PERFC_W'(1) : cyc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            valid_q <= 1'b0;
            sqn_q <= '0;
            pc_q <= '0;
            full_q <= 1'b0;
            rec_q <= '0;
            cyc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            sqn_q <= sqn_d;
            pc_q <= pc_d;
            full_q <= full_d;
            rec_q <= rec_d;
            cyc_q <= cyc_d;
        end
    end

    assign OUT_mispredFlush = state_q == FLUSH;
    assign OUT_rnStall = state_q == FLUSH;
    assign OUT_redirValid = valid_q;
    assign OUT_redirPC = pc_q;
    assign OUT_redirFull = full_q;
    assign OUT_recSqN = sqn_q;
    assign OUT_PERFC_recoveries = rec_q;
    assign OUT_PERFC_recoveryCycles = cyc_q;
endmodule

// File: tb/tb_mispred_recovery_ctrl.sv
// tb_mispred_recovery_ctrl: table-driven directed vectors plus reset sequences for mispred_recovery_ctrl.
module tb_mispred_recovery_ctrl;
    import mispred_pkg::*;

    logic clk = 1'b0;
    logic rst;
    BranchProv br;
    logic ready;
    logic flush_o, valid_o, full_o, stall_o;
    logic [31:0] pc_o, rec_o, cyc_o;
    logic [5:0] sqn_o;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mispred_recovery_ctrl #(.FLUSH_CYCLES(2), .PERFC_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .IN_branch(br),
        .IN_redirReady(ready),
        .OUT_mispredFlush(flush_o),
        .OUT_redirValid(valid_o),
        .OUT_redirPC(pc_o),
        .OUT_redirFull(full_o),
        .OUT_rnStall(stall_o),
        .OUT_recSqN(sqn_o),
        .OUT_PERFC_recoveries(rec_o),
        .OUT_PERFC_recoveryCycles(cyc_o)
    );

    typedef struct {
        logic tk, fl;
        logic [5:0] sqn;
        logic [31:0] pc;
        logic rdy;
        logic e_fl, e_v;
        logic [31:0] e_pc;
        logic e_full;
        logic [5:0] e_sqn;
        logic [31:0] e_rec, e_cyc;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t mk(logic tk, logic fl, logic [5:0] sqn, logic [31:0] pc, logic rdy,
                                logic e_fl, logic e_v, logic [31:0] e_pc, logic e_full,
                                logic [5:0] e_sqn, logic [31:0] e_rec, logic [31:0] e_cyc);
        mk = '{tk, fl, sqn, pc, rdy, e_fl, e_v, e_pc, e_full, e_sqn, e_rec, e_cyc};
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(logic tk, logic fl, logic [5:0] sqn, logic [31:0] pc, logic rdy);
        br = '{taken: tk, flush: fl, sqN: sqn, dstPC: pc};
        ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string name, int idx);
        chk({name, "_outs"}, idx, 32'({flush_o, valid_o, full_o, stall_o, |pc_o, |sqn_o}), 32'd0);
        chk({name, "_rec"}, idx, rec_o, 32'd0);
        chk({name, "_cyc"}, idx, cyc_o, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 10, 32'h1000, 1, 1, 1, 32'h1000, 0, 10, 1, 0);
        vecs[1]  = mk(0, 0, 0,  32'h0,    1, 1, 0, 32'h1000, 0, 10, 1, 1);
        vecs[2]  = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h1000, 0, 10, 1, 2);
        vecs[3]  = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h1000, 0, 10, 1, 2);
        vecs[4]  = mk(1, 0, 10, 32'h1000, 0, 1, 1, 32'h1000, 0, 10, 2, 2);
        vecs[5]  = mk(0, 0, 0,  32'h0,    0, 1, 1, 32'h1000, 0, 10, 2, 3);
        vecs[6]  = mk(0, 0, 0,  32'h0,    0, 1, 1, 32'h1000, 0, 10, 2, 4);
        vecs[7]  = mk(0, 0, 0,  32'h0,    0, 1, 1, 32'h1000, 0, 10, 2, 5);
        vecs[8]  = mk(0, 0, 0,  32'h0,    0, 1, 1, 32'h1000, 0, 10, 2, 6);
        vecs[9]  = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h1000, 0, 10, 2, 7);
        vecs[10] = mk(1, 0, 20, 32'h1800, 1, 1, 1, 32'h1800, 0, 20, 3, 7);
        vecs[11] = mk(1, 0, 15, 32'h2000, 1, 1, 1, 32'h2000, 0, 15, 3, 8);
        vecs[12] = mk(0, 0, 0,  32'h0,    1, 1, 0, 32'h2000, 0, 15, 3, 9);
        vecs[13] = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h2000, 0, 15, 3, 10);
        vecs[14] = mk(1, 0, 62, 32'h3000, 1, 1, 1, 32'h3000, 0, 62, 4, 10);
        vecs[15] = mk(1, 0, 1,  32'h3100, 1, 1, 0, 32'h3000, 0, 62, 4, 11);
        vecs[16] = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h3000, 0, 62, 4, 12);
        vecs[17] = mk(1, 0, 1,  32'h3100, 1, 1, 1, 32'h3100, 0, 1,  5, 12);
        vecs[18] = mk(1, 0, 62, 32'h3000, 1, 1, 1, 32'h3000, 0, 62, 5, 13);
        vecs[19] = mk(0, 0, 0,  32'h0,    1, 1, 0, 32'h3000, 0, 62, 5, 14);
        vecs[20] = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h3000, 0, 62, 5, 15);
        vecs[21] = mk(1, 1, 5,  32'h4000, 1, 1, 1, 32'h4000, 1, 5,  6, 15);
        vecs[22] = mk(1, 0, 3,  32'h4100, 1, 1, 0, 32'h4000, 1, 5,  6, 16);
        vecs[23] = mk(1, 1, 9,  32'h4200, 1, 1, 1, 32'h4200, 1, 9,  6, 17);
        vecs[24] = mk(0, 0, 0,  32'h0,    1, 1, 0, 32'h4200, 1, 9,  6, 18);
        vecs[25] = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h4200, 1, 9,  6, 19);
        vecs[26] = mk(1, 0, 30, 32'h5000, 1, 1, 1, 32'h5000, 0, 30, 7, 19);
        vecs[27] = mk(0, 0, 0,  32'h0,    1, 1, 0, 32'h5000, 0, 30, 7, 20);
        vecs[28] = mk(1, 0, 28, 32'h5100, 1, 1, 1, 32'h5100, 0, 28, 7, 21);
        vecs[29] = mk(1, 0, 28, 32'h5200, 1, 1, 0, 32'h5100, 0, 28, 7, 22);
        vecs[30] = mk(1, 0, 40, 32'h5300, 1, 0, 0, 32'h5100, 0, 28, 7, 23);
        vecs[31] = mk(1, 0, 40, 32'h5300, 1, 1, 1, 32'h5300, 0, 40, 8, 23);
        vecs[32] = mk(0, 0, 0,  32'h0,    1, 1, 0, 32'h5300, 0, 40, 8, 24);
        vecs[33] = mk(0, 0, 0,  32'h0,    1, 0, 0, 32'h5300, 0, 40, 8, 25);

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 6'($urandom), $urandom, 1'b1);
            chk_zero("reset", i);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
        chk_zero("post_reset", 0);

        for (int i = 0; i < 34; i++) begin
            step(vecs[i].tk, vecs[i].fl, vecs[i].sqn, vecs[i].pc, vecs[i].rdy);
            chk("flush", i, 32'(flush_o), 32'(vecs[i].e_fl));
            chk("rn_stall", i, 32'(stall_o), 32'(vecs[i].e_fl));
            chk("redir_valid", i, 32'(valid_o), 32'(vecs[i].e_v));
            chk("redir_pc", i, pc_o, vecs[i].e_pc);
            chk("redir_full", i, 32'(full_o), 32'(vecs[i].e_full));
            chk("rec_sqn", i, 32'(sqn_o), 32'(vecs[i].e_sqn));
            chk("perf_recoveries", i, rec_o, vecs[i].e_rec);
            chk("perf_cycles", i, cyc_o, vecs[i].e_cyc);
        end

        step(1'b1, 1'b0, 6'd7, 32'h6000, 1'b0);
        chk("mid_flush", 0, 32'({flush_o, valid_o}), 32'h3);
        chk("mid_pc", 0, pc_o, 32'h6000);
        step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
        chk("mid_hold", 0, 32'({flush_o, valid_o}), 32'h3);
        rst = 1'b1;
        step(1'b1, 1'b1, 6'd3, 32'h7000, 1'b0);
        chk_zero("mid_reset", 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
        chk_zero("after_mid_reset", 0);
        step(1'b1, 1'b0, 6'd12, 32'h8000, 1'b1);
        chk("restart_rec", 0, rec_o, 32'd1);
        chk("restart_pc", 0, pc_o, 32'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mispred_recovery_ctrl.md
Name: mispred_recovery_ctrl

Overview:
- Consumes the registered branch/flush decision (BranchProv) produced by the branch-selection stage.
- Sequences pipeline recovery. Generates the global mispredict-flush level, which also feeds back into the selector's mispredict perf gating.
- Drives a held-until-accepted fetch redirect and a rename stall.
- Arbitrates newer/older and full-flush events that arrive while a recovery is already in progress.

Parameters:
- FLUSH_CYCLES, 2: minimum cycles OUT_mispredFlush stays high per recovery (legal range 1..15).
- PERFC_W, 32: width of the perf counters (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- IN_branch  in  BranchProv  registered winning branch; fields used: taken, flush, sqN, dstPC
- IN_redirReady  in  1  fetch accepts redirect this cycle
- OUT_mispredFlush  out  1  recovery flush level to ROB/rename/IQs/selector
- OUT_redirValid  out  1  fetch redirect pending
- OUT_redirPC  out  dstPC width  redirect target
- OUT_redirFull  out  1  redirect is a full (non-speculative) flush
- OUT_rnStall  out  1  rename must not allocate
- OUT_recSqN  out  SqN  sqN of the branch being recovered
- OUT_PERFC_recoveries  out  PERFC_W  recoveries started
- OUT_PERFC_recoveryCycles  out  PERFC_W  cycles spent in FLUSH

Behaviour:
- All outputs registered. Reset: state=IDLE, every output 0, counters 0, latched sqN/PC/full=0.
- States: IDLE, FLUSH.
- IDLE, IN_branch.taken=1:
  - latch sqN, dstPC and full=IN_branch.flush;
  - cnt=FLUSH_CYCLES-1; go to FLUSH;
  - recoveries += 1.
  - Next cycle: OUT_mispredFlush=1, OUT_redirValid=1, OUT_rnStall=1. Latency from IN_branch.taken to outputs is exactly 1 cycle.
- IDLE, IN_branch.taken=0: nothing changes.
- FLUSH: recoveryCycles += 1 per cycle. cnt decrements to 0 and holds.
- Override in FLUSH: IN_branch.taken && (IN_branch.flush || (!full && $signed(IN_branch.sqN - recSqN) < 0)).
  - Relatch sqN/PC/full, reload cnt=FLUSH_CYCLES-1, re-assert OUT_redirValid with the new payload next cycle. This applies even if the old redirect was pending or was accepted that same cycle.
  - recoveries is NOT incremented.
  - A younger or equal-sqN non-full branch is ignored.
  - Once full=1, only another full flush overrides it.
- Redirect handshake:
  - Transfer occurs when OUT_redirValid && IN_redirReady.
  - Valid drops the following cycle unless an override occurs in the same cycle; override wins.
  - Payload is stable while valid except on override.
- Exit FLUSH→IDLE when cnt==0, redirect done (transferred earlier, or transferring this cycle), and no override this cycle.
  - Next cycle: OUT_mispredFlush=0, OUT_rnStall=0.
  - If the fetch stalls, flush stays high indefinitely.
- Taken branch arriving in the exit cycle counts as an override; the block remains in FLUSH.
- A taken branch in the first cycle after returning to IDLE starts a new recovery (recoveries += 1).
- sqN comparison uses a signed difference of SqN width, so wrap-around is handled.
- Perf counters saturate at all-ones.
- rst asserted mid-recovery: the next cycle is at reset values; pending redirect is dropped.
- FLUSH_CYCLES=1: with ready tied high, flush is high for exactly 1 cycle.

Test Plan:
- Reset sequencing:
  - Stimulus: rst held 3 cycles with IN_branch.taken=1 and random payload.
  - Required: all outputs 0 throughout and on the first cycle after release.
- Basic recovery:
  - Stimulus: FLUSH_CYCLES=2, ready=1, one taken branch sqN=10, dstPC=0x1000 at cycle t.
  - Required: redirValid/PC=0x1000 at t+1 only; mispredFlush and rnStall high t+1..t+2; recoveries=1; recoveryCycles=2.
- Fetch backpressure:
  - Stimulus: same branch, ready=0 until t+5.
  - Required: redirValid and mispredFlush held t+1..t+5 with constant PC; IDLE at t+6.
- Older override:
  - Stimulus: sqN=20 at t, then sqN=15 (PC 0x2000) at t+1, ready=1.
  - Required: redirect 0x2000 at t+2; flush ends after t+3; recoveries=1.
- Younger ignored across wrap:
  - Stimulus: 6-bit SqN; sqN=62 at t, then sqN=1 at t+1.
  - Required: ignored; recSqN stays 62. Reverse order (1 then 62): 62 overrides.
- Full-flush priority:
  - Stimulus: flush=1 sqN=5 at t, then non-full sqN=3 at t+1, then full sqN=9 at t+2.
  - Required: sqN=3 ignored; sqN=9 overrides; OUT_redirFull=1.
